wallace_baugh_wooley: RTL and testbench
=======================================

Name: wallace_baugh_wooley

Overview:
- Registered 8x8 signed (two's complement) multiplier producing a full 16-bit product.
- Partial products use the Baugh-Wooley signed scheme; they are reduced by a Wallace tree of full/half adders, then a final carry-propagate adder.
- Used as the MAC-datapath multiplier primitive in the accelerator; fully pipelined, accepts one operand pair per clock.

Parameters:
- None. Operand width is fixed at 8 bits and product width at 16 bits. No generic-width support.

Ports:
- clk        input   1   rising-edge clock
- rst_n      input   1   asynchronous active-low reset
- in_valid   input   1   a/b valid this cycle
- a          input   8   signed multiplicand
- b          input   8   signed multiplier
- out_valid  output  1   prod holds a new result this cycle
- prod       output  16  signed product a*b

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: prod=16'h0000, out_valid=0, all internal pipeline registers are cleared. Release is synchronous to clk.
- Partial products, for i,j in 0..6:
  - pp[i][j] = a[j] & b[i]
  - pp[i][7] = ~(a[7] & b[i])
  - pp[7][j] = ~(a[j] & b[7])
  - pp[7][7] = a[7] & b[7]
  - pp[i][j] has weight 2^(i+j).
- Correction constants: add 1 at bit 8 and 1 at bit 15. The sum is taken modulo 2^16 and equals the exact signed product.
- Reduction: Wallace tree (3:2 full adders, 2:2 half adders), column-wise, until two rows remain; then a 16-bit ripple or prefix CPA. The carry out of bit 15 is discarded.
- Must not use the behavioural '*' operator anywhere in the datapath.
- Latency is 1 cycle by default. When in_valid=1 at a rising edge, the next cycle shows prod=a*b and out_valid=1.
- When in_valid=0 at an edge: out_valid=0 the next cycle and prod holds its previous value.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs in order.
- The full range is exact. Extremes: -128*-128 = +16384, -128*127 = -16256, -128*-1 = +128 (fits in 16 bits, no saturation needed).
- Reset mid-operation: in-flight results are dropped; out_valid=0 until a new in_valid is accepted after reset release.
- No X propagation: when in_valid=0, a/b values are ignored for output update.

Optional Feature:
- Macro: WALLACE_BW_PIPE_EN.
- Defined: a pipeline register (with its own valid bit, reset to 0) is inserted between the Wallace tree output (the two final rows) and the CPA. Latency becomes 2 cycles; throughput is still one per cycle; the reset and hold rules apply at both stages.
- Undefined: single output register, latency 1, no intermediate register.

Test Plan:
- After reset, drive in order a/b = (2,3), (10,1), (1,1), (0,0), each with in_valid=1 → prod = 6, 10, 1, 0 respectively, at the stated latency, out_valid=1.
- a/b = (-1,-1), (127,-1), (-128,1), (-128,-1) → prod = 1, -127, -128, 128.
- Corners (-128,-128) → 16384; (-128,127) → -16256; (127,127) → 16129.
- Exhaustive sweep of all 65536 (a,b) pairs, back-to-back with in_valid=1, checked against a behavioural reference delayed by the latency → all match, out_valid continuously 1. Run with and without WALLACE_BW_PIPE_EN.
- Valid bubbles: in_valid pattern 1,0,1 with (5,-7), (99,99), (-3,4) → out_valid pattern 1,0,1; prod = -35, then held at -35, then -12.
- Assert rst_n=0 asynchronously while a valid result is in flight → prod=0 and out_valid=0 immediately without a clock edge. After release, no stale result appears.

Source files
------------

// File: rtl/wallace_baugh_wooley.sv
// Registered 8x8 signed multiplier: Baugh-Wooley partial products, Wallace reduction, ripple CPA.
// Define WALLACE_BW_PIPE_EN to register the two reduced rows ahead of the CPA (latency 2).
module wallace_baugh_wooley (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] prod
);

    logic [15:0] w_row0;
    logic [15:0] w_row1;
    logic [15:0] w_cpa_x;
    logic [15:0] w_cpa_y;
    logic [15:0] w_sum;
    logic        w_load;
    logic        r_out_valid;
    logic [15:0] r_prod;

    // Each column is a bag of bits; every stage compresses groups of three with
    // full adders and a leftover pair with a half adder until no column exceeds two.
    always_comb begin : wallace
        logic [11:0] col  [16];
        logic [11:0] nxt  [16];
        logic [3:0]  cnt  [16];
        logic [3:0]  ncnt [16];
        logic [3:0]  rem;
        logic [3:0]  pos;
        logic        busy;
        logic        bit_pp;
        logic        x;
        logic        y;
        logic        z;

        for (int c = 0; c < 16; c++) begin
            col[c]  = '0;
            nxt[c]  = '0;
            cnt[c]  = '0;
            ncnt[c] = '0;
        end
        rem    = '0;
        pos    = '0;
        busy   = 1'b0;
        bit_pp = 1'b0;
        x      = 1'b0;
        y      = 1'b0;
        z      = 1'b0;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i < 7 && j < 7)
                    bit_pp = a[j] & b[i];
                else if (i < 7)
                    bit_pp = ~(a[7] & b[i]);
                else if (j < 7)
                    bit_pp = ~(a[j] & b[7]);
                else
                    bit_pp = a[7] & b[7];
                col[i+j][cnt[i+j]] = bit_pp;
                cnt[i+j] = cnt[i+j] + 4'd1;
            end
        end
        // Baugh-Wooley correction terms
        col[8][cnt[8]]   = 1'b1;
        cnt[8]           = cnt[8] + 4'd1;
        col[15][cnt[15]] = 1'b1;
        cnt[15]          = cnt[15] + 4'd1;

        for (int s = 0; s < 6; s++) begin
            busy = 1'b0;
            for (int c = 0; c < 16; c++)
                if (cnt[c] > 4'd2) busy = 1'b1;
            if (busy) begin
                for (int c = 0; c < 16; c++) begin
                    nxt[c]  = '0;
                    ncnt[c] = '0;
                end
                for (int c = 0; c < 16; c++) begin
                    rem = cnt[c];
                    pos = '0;
                    for (int g = 0; g < 4; g++) begin
                        if (rem >= 4'd3) begin
                            x = col[c][pos];
                            y = col[c][pos+4'd1];
                            z = col[c][pos+4'd2];
                            nxt[c][ncnt[c]] = x ^ y ^ z;
                            ncnt[c] = ncnt[c] + 4'd1;
                            if (c < 15) begin
                                nxt[c+1][ncnt[c+1]] = (x & y) | (z & (x ^ y));
                                ncnt[c+1] = ncnt[c+1] + 4'd1;
                            end
                            rem = rem - 4'd3;
                            pos = pos + 4'd3;
                        end
                    end
                    if (rem == 4'd2) begin
                        x = col[c][pos];
                        y = col[c][pos+4'd1];
                        nxt[c][ncnt[c]] = x ^ y;
                        ncnt[c] = ncnt[c] + 4'd1;
                        if (c < 15) begin
                            nxt[c+1][ncnt[c+1]] = x & y;
                            ncnt[c+1] = ncnt[c+1] + 4'd1;
                        end
                    end else if (rem == 4'd1) begin
                        nxt[c][ncnt[c]] = col[c][pos];
                        ncnt[c] = ncnt[c] + 4'd1;
                    end
                end
                for (int c = 0; c < 16; c++) begin
                    col[c] = nxt[c];
                    cnt[c] = ncnt[c];
                end
            end
        end

        for (int c = 0; c < 16; c++) begin
            w_row0[c] = col[c][0];
            w_row1[c] = col[c][1];
        end
    end

`ifdef WALLACE_BW_PIPE_EN
    logic        r_mid_valid;
    logic [15:0] r_row0;
    logic [15:0] r_row1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mid_valid <= 1'b0;
            r_row0      <= '0;
            r_row1      <= '0;
        end else begin
            r_mid_valid <= in_valid;
            if (in_valid) begin
                r_row0 <= w_row0;
                r_row1 <= w_row1;
            end
        end
    end

    assign w_cpa_x = r_row0;
    assign w_cpa_y = r_row1;
    assign w_load  = r_mid_valid;
`else
    assign w_cpa_x = w_row0;
    assign w_cpa_y = w_row1;
    assign w_load  = in_valid;
`endif

    // Carry out of bit 15 is dropped: the result is taken modulo 2^16.
    always_comb begin : cpa
        logic carry;
        carry = 1'b0;
        w_sum = '0;
        for (int i = 0; i < 16; i++) begin
            w_sum[i] = w_cpa_x[i] ^ w_cpa_y[i] ^ carry;
            carry    = (w_cpa_x[i] & w_cpa_y[i]) | (carry & (w_cpa_x[i] ^ w_cpa_y[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_prod      <= '0;
        end else begin
            r_out_valid <= w_load;
            if (w_load) r_prod <= w_sum;
        end
    end

    assign out_valid = r_out_valid;
    assign prod      = r_prod;

endmodule

// File: tb/tb_wallace_baugh_wooley.sv
// Directed-vector bench for wallace_baugh_wooley; tracks latency 1 or 2 depending on WALLACE_BW_PIPE_EN.
module tb_wallace_baugh_wooley;

`ifdef WALLACE_BW_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic [15:0] prod;

    int n_checks = 0;
    int n_errors = 0;
    int last_p;

    typedef struct {
        logic v;
        int   p;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    wallace_baugh_wooley dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .prod      (prod)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic init_model();
        q.delete();
        for (int i = 0; i < LAT - 1; i++) q.push_back('{1'b0, 0});
        last_p = 0;
    endtask

    // Called at a falling edge; drives one cycle and checks the output due now.
    task automatic step(input string tag, input logic v, input int va, input int vb, input int pexp);
        exp_t e;
        in_valid = v;
        a        = 8'(va);
        b        = 8'(vb);
        @(posedge clk);
        @(negedge clk);
        q.push_back('{v, pexp});
        e = q.pop_front();
        if (e.v) last_p = e.p;
        check_val({tag, " out_valid"}, int'(out_valid), int'(e.v));
        check_val({tag, " prod"}, int'($signed(prod)), last_p);
    endtask

    task automatic flush();
        for (int i = 0; i < LAT; i++) step("flush", 1'b0, 0, 0, 0);
    endtask

    int va_t [11] = '{2, 10, 1, 0, -1, 127, -128, -128, -128, -128, 127};
    int vb_t [11] = '{3, 1, 1, 0, -1, -1, 1, -1, -128, 127, 127};
    int pe_t [11] = '{6, 10, 1, 0, 1, -127, -128, 128, 16384, -16256, 16129};

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        check_val("reset out_valid", int'(out_valid), 0);
        check_val("reset prod", int'($signed(prod)), 0);
        rst_n = 1'b1;
        init_model();

        for (int k = 0; k < 11; k++) step($sformatf("vec%0d", k), 1'b1, va_t[k], vb_t[k], pe_t[k]);
        flush();

        step("bubble0", 1'b1, 5, -7, -35);
        step("bubble1", 1'b0, 99, 99, 0);
        step("bubble2", 1'b1, -3, 4, -12);
        flush();

        for (int ia = -128; ia < 128; ia++)
            for (int ib = -128; ib < 128; ib++)
                step("sweep", 1'b1, ia, ib, ia * ib);
        flush();

        in_valid = 1'b1;
        a        = 8'd7;
        b        = 8'd9;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst out_valid", int'(out_valid), 0);
        check_val("async_rst prod", int'($signed(prod)), 0);
        in_valid = 1'b0;
        a        = 8'h55;
        b        = 8'h55;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        init_model();
        for (int i = 0; i < LAT + 1; i++) step("post_rst", 1'b0, 85, 85, 0);
        step("after_rst", 1'b1, 3, -5, -15);
        flush();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
